// File: rtl/seg7_frame_decoder.sv
// Receive side of a 4-digit multiplexed 7-segment display: waits for the
// active-low scan lines to settle, decodes each digit and reassembles frames.
module seg7_frame_decoder #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:6]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        changed,
  output logic        seg_error
);

  localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  logic [0:6]  seg_prev;
  logic [3:0]  an_prev;
  logic [7:0]  cnt;
  logic        stable;
  logic        one_low;
  logic [1:0]  sel;
  logic        sample;
  logic        complete;
  logic [3:0]  nib;
  logic        is_blank;
  logic        is_err;
  logic [3:0]  mask;
  logic [15:0] store_value;
  logic [3:0]  store_blank;
  logic [3:0]  store_err;

  assign stable   = (seg == seg_prev) && (an == an_prev);
  assign complete = (mask == 4'hF);
  // Fires only on the transition into SETTLE, so a long dwell samples once.
  assign sample   = stable && one_low && (cnt == SETTLE_LAST);

  always_comb begin
    one_low = 1'b1;
    sel     = 2'd0;
    case (an_prev)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    nib      = 4'h0;
    is_blank = 1'b0;
    is_err   = 1'b0;
    case (seg_prev)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      7'b1111111: is_blank = 1'b1;
      default:    is_err   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_prev <= '0;
      an_prev  <= '0;
      cnt      <= '0;
    end else begin
      seg_prev <= seg;
      an_prev  <= an;
      if (!stable)
        cnt <= '0;
      else if (cnt < SETTLE_MAX)
        cnt <= cnt + 8'd1;
    end
  end

  // A sample in the completion cycle wins over the clear, starting the next frame.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        store_value[gi*4 +: 4] <= 4'h0;
        store_blank[gi]        <= 1'b0;
        store_err[gi]          <= 1'b0;
        mask[gi]               <= 1'b0;
      end else if (sample && (sel == 2'(gi))) begin
        store_value[gi*4 +: 4] <= nib;
        store_blank[gi]        <= is_blank;
        store_err[gi]          <= is_err;
        mask[gi]               <= 1'b1;
      end else if (complete) begin
        store_value[gi*4 +: 4] <= 4'h0;
        store_blank[gi]        <= 1'b0;
        store_err[gi]          <= 1'b0;
        mask[gi]               <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value       <= 16'h0000;
      blank       <= 4'hF;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
      seg_error   <= 1'b0;
    end else begin
      frame_valid <= complete;
      changed     <= 1'b0;
      if (complete) begin
        value     <= store_value;
        blank     <= store_blank;
        seg_error <= |store_err;
        changed   <= ({store_value, store_blank} != {value, blank});
      end
    end
  end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder: table of full frames plus hand-written
// sequences for glitches, illegal anodes, resampling, latency and mid-frame reset.
module tb_seg7_frame_decoder;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0000100, SA = 7'b0001000, SB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001, SD = 7'b1000010, SE = 7'b0110000, SF = 7'b0111000;
  localparam logic [6:0] SBL = 7'b1111111, SERR = 7'b1010101;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        frame_valid, changed, seg_error;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  int fv_base;
  logic cap_changed = 1'b0;

  typedef struct packed {
    logic [3:0][6:0] pat;
    logic [15:0]     exp_value;
    logic [3:0]      exp_blank;
    logic            exp_changed;
    logic            exp_err;
  } vec_t;

  vec_t vecs [7];

  seg7_frame_decoder #(.SETTLE(4)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .value(value), .blank(blank),
    .frame_valid(frame_valid), .changed(changed), .seg_error(seg_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_count++;
      cap_changed = changed;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] an_for(input int k);
    logic [3:0] one;
    one = 4'b0001 << k;
    return ~one;
  endfunction

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_frame(input string name, input int fv_exp, input logic [15:0] v,
                             input logic [3:0] b, input logic ch, input logic e);
    check({name, ".frames"}, fv_count - fv_base, fv_exp);
    check({name, ".value"}, value, v);
    check({name, ".blank"}, blank, b);
    check({name, ".changed"}, cap_changed, ch);
    check({name, ".seg_error"}, seg_error, e);
    $display("%s: value=%h blank=%b changed=%b seg_error=%b frames=%0d",
             name, value, blank, cap_changed, seg_error, fv_count - fv_base);
  endtask

  initial begin
    int lat;
    vecs[0] = '{pat:{S1, S2, S3, S4},   exp_value:16'h1234, exp_blank:4'b0000, exp_changed:1'b1, exp_err:1'b0};
    vecs[1] = '{pat:{S1, S2, S3, S4},   exp_value:16'h1234, exp_blank:4'b0000, exp_changed:1'b0, exp_err:1'b0};
    vecs[2] = '{pat:{S5, S6, S7, S8},   exp_value:16'h5678, exp_blank:4'b0000, exp_changed:1'b1, exp_err:1'b0};
    vecs[3] = '{pat:{S9, SA, SB, SC},   exp_value:16'h9ABC, exp_blank:4'b0000, exp_changed:1'b1, exp_err:1'b0};
    vecs[4] = '{pat:{SD, SE, SF, S0},   exp_value:16'hDEF0, exp_blank:4'b0000, exp_changed:1'b1, exp_err:1'b0};
    vecs[5] = '{pat:{SBL, S2, S2, SERR}, exp_value:16'h0220, exp_blank:4'b1000, exp_changed:1'b1, exp_err:1'b1};
    vecs[6] = '{pat:{S3, S3, S3, S3},   exp_value:16'h3333, exp_blank:4'b0000, exp_changed:1'b1, exp_err:1'b0};

    reset = 1'b0;
    an    = 4'hF;
    seg   = SBL;
    repeat (3) @(negedge clk);
    check("reset.value", value, 16'h0000);
    check("reset.blank", blank, 4'hF);
    check("reset.frame_valid", frame_valid, 1'b0);
    check("reset.changed", changed, 1'b0);
    check("reset.seg_error", seg_error, 1'b0);
    reset = 1'b1;
    dwell(4'hF, SBL, 5);

    for (int i = 0; i < 7; i++) begin
      fv_base = fv_count;
      for (int k = 0; k < 4; k++) dwell(an_for(k), vecs[i].pat[k], 10);
      check_frame($sformatf("table%0d", i), 1, vecs[i].exp_value, vecs[i].exp_blank,
                  vecs[i].exp_changed, vecs[i].exp_err);
    end

    // Error frame followed by clean frame already covered; now the 3-cycle glitch.
    fv_base = fv_count;
    dwell(4'b1110, S9, 3);
    for (int k = 1; k < 4; k++) dwell(an_for(k), S0, 10);
    check("glitch.no_frame", fv_count - fv_base, 0);
    dwell(4'b1110, S0, 10);
    check_frame("glitch", 1, 16'h0000, 4'b0000, 1'b1, 1'b0);

    // Two-low and all-high anodes must never count as a digit.
    fv_base = fv_count;
    dwell(4'b1100, S5, 20);
    dwell(4'b1111, S5, 20);
    check("multilow.no_frame", fv_count - fv_base, 0);
    check("multilow.value", value, 16'h0000);
    for (int k = 1; k < 4; k++) dwell(an_for(k), S1, 10);
    check("multilow.partial", fv_count - fv_base, 0);
    dwell(4'b1110, S1, 10);
    check_frame("multilow", 1, 16'h1111, 4'b0000, 1'b1, 1'b0);

    fv_base = fv_count;
    dwell(4'b1110, S1, 10);
    dwell(4'b1101, S2, 10);
    dwell(4'b1110, S7, 10);
    dwell(4'b1011, S3, 10);
    dwell(4'b0111, S4, 10);
    check_frame("resample", 1, 16'h4327, 4'b0000, 1'b1, 1'b0);

    // Latency from the start of the final dwell to frame_valid: SETTLE+2.
    fv_base = fv_count;
    for (int k = 0; k < 3; k++) dwell(an_for(k), S8, 10);
    an  = 4'b0111;
    seg = S8;
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (frame_valid && lat < 0) lat = c;
    end
    @(negedge clk);
    check("latency.cycles", lat, 6);
    check_frame("latency", 1, 16'h8888, 4'b0000, 1'b1, 1'b0);

    fv_base = fv_count;
    for (int k = 0; k < 3; k++) dwell(an_for(k), S5, 10);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset.value", value, 16'h0000);
    check("midreset.blank", blank, 4'hF);
    reset = 1'b1;
    dwell(4'b0111, S5, 10);
    check("midreset.no_frame", fv_count - fv_base, 0);
    check("midreset.hold_value", value, 16'h0000);
    check("midreset.hold_blank", blank, 4'hF);
    for (int k = 0; k < 4; k++) dwell(an_for(k), S5, 10);
    check_frame("midreset", 1, 16'h5555, 4'b0000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
